gen_step_controller: RTL

- Generation sequencer for the Life board. It replaces the derived simClock, the clock mux and the standalone state counter with a single-clock controller.
- It issues one-cycle step strobes to the board in three modes: manual, free-run at a selectable rate, and burst of N generations.
- It waits for the board's completion handshake before issuing another strobe, and it owns the generation counter shown on the HEX displays.

---
 rtl/gol_ctrl_pkg.sv | 31 +++
 rtl/sync_edge_detect.sv | 30 +++
 rtl/gen_step_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/gol_ctrl_pkg.sv
// Purpose: shared encodings for the Life-board generation controller.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package gol_ctrl_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_RUN    = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        BURST,
        ISSUE,
        WAIT
    } state_t;

    // Rate divider reload values, indexed by rate_sel (entry 0 is the slowest, 1 Hz at 50 MHz).
    localparam logic [3:0][31:0] RATE_DIV = {
        32'd3_125_000,
        32'd12_500_000,
        32'd25_000_000,
        32'd50_000_000
    };

    // Encoding 2'b11 is not a real mode; it behaves like manual.
    function automatic logic is_manual(input logic [1:0] m);
        return (m == MODE_MANUAL) || (m == 2'b11);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Purpose: 2-FF synchroniser for an asynchronous level plus a rising-edge pulse.
// Latency: pulse is high in the cycle after the second synchroniser flop captures the edge.
// Backpressure: none; one pulse per rising edge, held levels produce nothing further.
// Ports: clock, resetn (async active-low), din (async level), pulse (one-cycle, clock domain).
module sync_edge_detect (
    input  logic clock,
    input  logic resetn,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign pulse = sync & ~sync_d;

endmodule

// File: rtl/gen_step_controller.sv
// Purpose: single-clock generation sequencer for the Life board (manual / free-run / burst).
// Latency: step_en rises 3 cycles after a step_req edge; free-run/burst steps issue on divider ticks.
// Backpressure: one step in flight; waits for step_done (or DONE_TIMEOUT cycles), extra requests dropped.
// Ports: clock, resetn, mode, rate_sel, step_req, burst_start, burst_len, load, step_done in;
//        step_en, busy, gen_count, burst_remaining, timeout_err out.
// Optional: `define STOP_ON_STILL_EN adds board_changed in and still_flag out (stop on a still board).
module gen_step_controller
    import gol_ctrl_pkg::*;
#(
    parameter int               COUNT_WIDTH  = 16,
    parameter int               DIV_WIDTH    = 26,
    parameter int               BURST_WIDTH  = 8,
    parameter int               DONE_TIMEOUT = 1023,
    parameter logic [3:0][31:0] RATE_TABLE   = RATE_DIV
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [1:0]             mode,
    input  logic [1:0]             rate_sel,
    input  logic                   step_req,
    input  logic                   burst_start,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic                   load,
    input  logic                   step_done,
    output logic                   step_en,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] gen_count,
    output logic [BURST_WIDTH-1:0] burst_remaining,
    output logic                   timeout_err
`ifdef STOP_ON_STILL_EN
    ,
    input  logic                   board_changed,
    output logic                   still_flag
`endif
);

    localparam int                 TMO_W     = $clog2(DONE_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TMO_LIMIT = TMO_W'(DONE_TIMEOUT);

    state_t                 state;
    logic                   step_pulse;
    logic                   burst_pulse;
    logic [DIV_WIDTH-1:0]   div_cnt;
    logic [DIV_WIDTH-1:0]   div_max;
    logic [1:0]             rate_sel_q;
    logic                   div_active;
    logic                   tick;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   burst_step;
    logic [BURST_WIDTH-1:0] rem_dec;
`ifdef STOP_ON_STILL_EN
    logic                   auto_step;
    logic                   run_block;   // holds off free-run after a still stop until mode leaves 01
`endif

    sync_edge_detect u_step_sync (
        .clock  (clock),
        .resetn (resetn),
        .din    (step_req),
        .pulse  (step_pulse)
    );

    sync_edge_detect u_burst_sync (
        .clock  (clock),
        .resetn (resetn),
        .din    (burst_start),
        .pulse  (burst_pulse)
    );

    // Rate divider: only runs while waiting for the next automatic step, restarts on a rate change.
    assign div_active = (state == RUN) || (state == BURST);
    assign div_max    = DIV_WIDTH'(RATE_TABLE[rate_sel] - 32'd1);
    assign tick       = div_active && (rate_sel == rate_sel_q) && (div_cnt == div_max);
    assign rem_dec    = burst_remaining - BURST_WIDTH'(1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_cnt    <= '0;
            rate_sel_q <= '0;
        end else begin
            rate_sel_q <= rate_sel;
            if (!div_active || (rate_sel != rate_sel_q) || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            step_en         <= 1'b0;
            busy            <= 1'b0;
            gen_count       <= '0;
            burst_remaining <= '0;
            timeout_err     <= 1'b0;
            tmo_cnt         <= '0;
            burst_step      <= 1'b0;
`ifdef STOP_ON_STILL_EN
            auto_step       <= 1'b0;
            run_block       <= 1'b0;
            still_flag      <= 1'b0;
`endif
        end else if (load) begin
            // load wins over everything, including a completion landing this cycle.
            state           <= IDLE;
            step_en         <= 1'b0;
            busy            <= 1'b0;
            gen_count       <= '0;
            burst_remaining <= '0;
            timeout_err     <= 1'b0;
            tmo_cnt         <= '0;
            burst_step      <= 1'b0;
`ifdef STOP_ON_STILL_EN
            auto_step       <= 1'b0;
            run_block       <= 1'b0;
            still_flag      <= 1'b0;
`endif
        end else begin
            step_en <= 1'b0;
`ifdef STOP_ON_STILL_EN
            if (mode != MODE_RUN) begin
                run_block <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (is_manual(mode)) begin
                        if (step_pulse) begin
                            state      <= ISSUE;
                            step_en    <= 1'b1;
                            busy       <= 1'b1;
                            burst_step <= 1'b0;
`ifdef STOP_ON_STILL_EN
                            auto_step  <= 1'b0;
                            still_flag <= 1'b0;
`endif
                        end
                    end else if (mode == MODE_RUN) begin
`ifdef STOP_ON_STILL_EN
                        if (!run_block) begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end else if (burst_pulse && (burst_len != '0)) begin
                        burst_remaining <= burst_len;
                        state           <= BURST;
                    end
                end
                RUN: begin
                    if (mode != MODE_RUN) begin
                        state <= IDLE;
                    end else if (tick) begin
                        state      <= ISSUE;
                        step_en    <= 1'b1;
                        busy       <= 1'b1;
                        burst_step <= 1'b0;
`ifdef STOP_ON_STILL_EN
                        auto_step  <= 1'b1;
`endif
                    end
                end
                BURST: begin
                    if (tick) begin
                        state      <= ISSUE;
                        step_en    <= 1'b1;
                        busy       <= 1'b1;
                        burst_step <= 1'b1;
`ifdef STOP_ON_STILL_EN
                        auto_step  <= 1'b1;
`endif
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    tmo_cnt <= '0;
                end
                WAIT: begin
                    if (step_done || (tmo_cnt == TMO_LIMIT)) begin
                        gen_count <= gen_count + COUNT_WIDTH'(1);
                        busy      <= 1'b0;
                        if (!step_done) begin
                            timeout_err <= 1'b1;
                        end
`ifdef STOP_ON_STILL_EN
                        if (step_done && !board_changed && auto_step) begin
                            still_flag      <= 1'b1;
                            run_block       <= 1'b1;
                            burst_remaining <= '0;
                            state           <= IDLE;
                        end else
`endif
                        if (burst_step && (rem_dec != '0) && (mode == MODE_BURST)) begin
                            burst_remaining <= rem_dec;
                            state           <= BURST;
                        end else begin
                            // Burst finished or abandoned by a mode change: nothing left to run.
                            burst_remaining <= '0;
                            state           <= (mode == MODE_RUN) ? RUN : IDLE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
